// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: instruction codes, datapath
// select values, FSM state encoding and the per-instruction decode table.
package multicycle_controller_pkg;

  localparam int unsigned INST_ADDU  = 1;
  localparam int unsigned INST_SUBU  = 2;
  localparam int unsigned INST_ORI   = 3;
  localparam int unsigned INST_LUI   = 4;
  localparam int unsigned INST_ADDI  = 5;
  localparam int unsigned INST_ADDIU = 6;
  localparam int unsigned INST_SLT   = 7;
  localparam int unsigned INST_LW    = 8;
  localparam int unsigned INST_LB    = 9;
  localparam int unsigned INST_SW    = 10;
  localparam int unsigned INST_SB    = 11;
  localparam int unsigned INST_BEQ   = 12;
  localparam int unsigned INST_J     = 13;
  localparam int unsigned INST_JAL   = 14;
  localparam int unsigned INST_JR    = 15;
  localparam int unsigned INST_HLT   = 16;

  localparam logic [1:0] ALU_SEL_ADD = 2'd0;
  localparam logic [1:0] ALU_SEL_SUB = 2'd1;
  localparam logic [1:0] ALU_SEL_OR  = 2'd2;
  localparam logic [1:0] ALU_SEL_SLT = 2'd3;

  localparam logic       ALU_SRC_REG = 1'b0;
  localparam logic       ALU_SRC_EXT = 1'b1;

  localparam logic [1:0] EXT_SIGN = 2'd0;
  localparam logic [1:0] EXT_ZERO = 2'd1;
  localparam logic [1:0] EXT_HIGH = 2'd2;

  localparam logic [1:0] GPR_ADDR_RT = 2'd0;
  localparam logic [1:0] GPR_ADDR_RD = 2'd1;
  localparam logic [1:0] GPR_ADDR_RA = 2'd2;

  localparam logic [1:0] GPR_DATA_ALU = 2'd0;
  localparam logic [1:0] GPR_DATA_MEM = 2'd1;
  localparam logic [1:0] GPR_DATA_PC  = 2'd2;

  localparam logic [1:0] IFU_SEL_NORM       = 2'd0;
  localparam logic [1:0] IFU_SEL_RELATIVE   = 2'd1;
  localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'd2;
  localparam logic [1:0] IFU_SEL_REGISTER   = 2'd3;

  localparam logic DM_WORD = 1'b0;
  localparam logic DM_BYTE = 1'b1;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_BAD, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_J, CLS_JAL, CLS_JR, CLS_HLT
  } inst_cls_e;

  typedef struct packed {
    inst_cls_e  cls;
    logic [1:0] alu_sel;
    logic       alu_src;
    logic [1:0] ext;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic       dm_sel;
    logic       of_en;
  } decode_t;

  function automatic decode_t decode(input int unsigned code);
    decode_t d;
    d = '{cls: CLS_BAD, alu_sel: ALU_SEL_ADD, alu_src: ALU_SRC_EXT, ext: EXT_SIGN,
          addr_sel: GPR_ADDR_RT, data_sel: GPR_DATA_ALU, dm_sel: DM_WORD, of_en: 1'b0};
    case (code)
      INST_ADDU:  begin d.cls = CLS_ALU; d.alu_src = ALU_SRC_REG; d.addr_sel = GPR_ADDR_RD; end
      INST_SUBU:  begin d.cls = CLS_ALU; d.alu_sel = ALU_SEL_SUB; d.alu_src = ALU_SRC_REG;
                        d.addr_sel = GPR_ADDR_RD; end
      INST_SLT:   begin d.cls = CLS_ALU; d.alu_sel = ALU_SEL_SLT; d.alu_src = ALU_SRC_REG;
                        d.addr_sel = GPR_ADDR_RD; end
      INST_ORI:   begin d.cls = CLS_ALU; d.alu_sel = ALU_SEL_OR; d.ext = EXT_ZERO; end
      INST_LUI:   begin d.cls = CLS_ALU; d.ext = EXT_HIGH; end
      INST_ADDI:  begin d.cls = CLS_ALU; d.of_en = 1'b1; end
      INST_ADDIU: d.cls = CLS_ALU;
      INST_LW:    begin d.cls = CLS_LOAD; d.data_sel = GPR_DATA_MEM; end
      INST_LB:    begin d.cls = CLS_LOAD; d.data_sel = GPR_DATA_MEM; d.dm_sel = DM_BYTE; end
      INST_SW:    d.cls = CLS_STORE;
      INST_SB:    begin d.cls = CLS_STORE; d.dm_sel = DM_BYTE; end
      INST_BEQ:   begin d.cls = CLS_BEQ; d.alu_sel = ALU_SEL_SUB; d.alu_src = ALU_SRC_REG; end
      INST_J:     d.cls = CLS_J;
      INST_JAL:   begin d.cls = CLS_JAL; d.addr_sel = GPR_ADDR_RA; d.data_sel = GPR_DATA_PC; end
      INST_JR:    d.cls = CLS_JR;
      INST_HLT:   d.cls = CLS_HLT;
      default:    d.cls = CLS_BAD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// Free-running wrap-around counter with synchronous clear and count enable.
module mc_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake stalls, sticky halt, bad-instruction pulse and perf counters.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 when memory is ready
// DECODE | resolve jumps and halt, flag undefined codes
// EXEC   | ALU operation, branch resolution
// MEM    | data memory access, held until memory is ready
// WB     | register file write-back
// HALT   | sticky stop until reset
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int INST_W      = 6,
  parameter int CNT_W       = 32,
  parameter int OF_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] dec_inst,
  input  logic              zero,
  input  logic              overflow,
  input  logic              mem_ready,
  output logic              pc_write_en,
  output logic              ir_write_en,
  output logic              reg_write_en,
  output logic              reg_of_en,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic              inst_fetch,
  output logic [1:0]        alu_sel,
  output logic [1:0]        gpr_write_addr_sel,
  output logic [1:0]        gpr_write_data_sel,
  output logic [1:0]        ext_ctl,
  output logic [1:0]        npc_sel,
  output logic              alu_src_ctl,
  output logic              dm_sel,
  output logic              halt_sig,
  output logic              bad_inst,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt
);

  localparam logic OF_SUP = (OF_SUPPRESS != 0);

  state_e  state_q, state_d;
  decode_t dec;
  logic    retire;

  assign dec                = decode(32'(dec_inst));
  assign alu_sel            = dec.alu_sel;
  assign alu_src_ctl        = dec.alu_src;
  assign ext_ctl            = dec.ext;
  assign gpr_write_addr_sel = dec.addr_sel;
  assign gpr_write_data_sel = dec.data_sel;
  assign dm_sel             = dec.dm_sel;
  assign state              = state_q;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (dec.cls)
          CLS_HLT:                          state_d = ST_HALT;
          CLS_J, CLS_JAL, CLS_JR, CLS_BAD:  state_d = ST_FETCH;
          default:                          state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (dec.cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_ALU:             state_d = ST_WB;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)
          state_d = ST_MEM;
        else if (dec.cls == CLS_LOAD)
          state_d = ST_WB;
        else
          state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset forces every strobe low even though the state is already FETCH.
  always_comb begin
    pc_write_en  = 1'b0;
    ir_write_en  = 1'b0;
    reg_write_en = 1'b0;
    reg_of_en    = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    inst_fetch   = 1'b1;
    npc_sel      = IFU_SEL_NORM;
    halt_sig     = 1'b0;
    bad_inst     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_read_en = 1'b1;
          if (mem_ready) begin
            ir_write_en = 1'b1;
            pc_write_en = 1'b1;
          end
        end
        ST_DECODE: begin
          case (dec.cls)
            CLS_J: begin
              pc_write_en = 1'b1;
              npc_sel     = IFU_SEL_IRRELATIVE;
            end
            CLS_JAL: begin
              pc_write_en  = 1'b1;
              npc_sel      = IFU_SEL_IRRELATIVE;
              reg_write_en = 1'b1;
            end
            CLS_JR: begin
              pc_write_en = 1'b1;
              npc_sel     = IFU_SEL_REGISTER;
            end
            CLS_BAD: bad_inst = 1'b1;
            default: ;
          endcase
        end
        ST_EXEC: begin
          if (dec.cls == CLS_BEQ) begin
            pc_write_en = zero;
            npc_sel     = IFU_SEL_RELATIVE;
          end
        end
        ST_MEM: begin
          inst_fetch   = 1'b0;
          mem_read_en  = (dec.cls == CLS_LOAD);
          mem_write_en = (dec.cls == CLS_STORE);
        end
        ST_WB: begin
          reg_of_en    = dec.of_en;
          reg_write_en = ~(OF_SUP & dec.of_en & overflow);
        end
        ST_HALT: halt_sig = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    retire = (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) &&
             (state_d inside {ST_FETCH, ST_HALT}) &&
             !(state_q == ST_DECODE && dec.cls == CLS_BAD);
  end

  mc_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (rst),
    .en  (state_q != ST_HALT),
    .cnt (cycle_cnt)
  );

  mc_perf_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk (clk),
    .clr (rst),
    .en  (retire),
    .cnt (inst_cnt)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; a second instance with overflow
// suppression disabled shares the stimulus.
module tb_multicycle_controller;

  localparam logic [5:0] C_ADDU = 6'd1;
  localparam logic [5:0] C_SUBU = 6'd2;
  localparam logic [5:0] C_ADDI = 6'd5;
  localparam logic [5:0] C_LW   = 6'd8;
  localparam logic [5:0] C_SW   = 6'd10;
  localparam logic [5:0] C_BEQ  = 6'd12;
  localparam logic [5:0] C_JAL  = 6'd14;
  localparam logic [5:0] C_HLT  = 6'd16;
  localparam logic [5:0] C_BAD  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  dec_inst;
  logic        zero, overflow, mem_ready;

  logic        pc_write_en, ir_write_en, reg_write_en, reg_of_en, mem_write_en, mem_read_en;
  logic        inst_fetch, alu_src_ctl, dm_sel, halt_sig, bad_inst;
  logic [1:0]  alu_sel, gpr_write_addr_sel, gpr_write_data_sel, ext_ctl, npc_sel;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, inst_cnt;

  logic        ns_pc_write_en, ns_ir_write_en, ns_reg_write_en, ns_reg_of_en;
  logic        ns_mem_write_en, ns_mem_read_en, ns_inst_fetch, ns_alu_src_ctl, ns_dm_sel;
  logic        ns_halt_sig, ns_bad_inst;
  logic [1:0]  ns_alu_sel, ns_gpr_write_addr_sel, ns_gpr_write_data_sel, ns_ext_ctl, ns_npc_sel;
  logic [2:0]  ns_state;
  logic [31:0] ns_cycle_cnt, ns_inst_cnt;

  int ntests = 0;
  int nfail  = 0;

  logic [2:0] exp_st  [9];
  logic       exp_mr  [9];
  logic       exp_irw [9];
  logic       exp_mrd [9];
  logic       exp_rwe [9];

  always #5 clk = ~clk;

  multicycle_controller #(.INST_W(6), .CNT_W(32), .OF_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .dec_inst(dec_inst), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .pc_write_en(pc_write_en), .ir_write_en(ir_write_en),
    .reg_write_en(reg_write_en), .reg_of_en(reg_of_en), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .inst_fetch(inst_fetch), .alu_sel(alu_sel),
    .gpr_write_addr_sel(gpr_write_addr_sel), .gpr_write_data_sel(gpr_write_data_sel),
    .ext_ctl(ext_ctl), .npc_sel(npc_sel), .alu_src_ctl(alu_src_ctl), .dm_sel(dm_sel),
    .halt_sig(halt_sig), .bad_inst(bad_inst), .state(state), .cycle_cnt(cycle_cnt),
    .inst_cnt(inst_cnt)
  );

  multicycle_controller #(.INST_W(6), .CNT_W(32), .OF_SUPPRESS(0)) dut_ns (
    .clk(clk), .rst(rst), .dec_inst(dec_inst), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .pc_write_en(ns_pc_write_en), .ir_write_en(ns_ir_write_en),
    .reg_write_en(ns_reg_write_en), .reg_of_en(ns_reg_of_en), .mem_write_en(ns_mem_write_en),
    .mem_read_en(ns_mem_read_en), .inst_fetch(ns_inst_fetch), .alu_sel(ns_alu_sel),
    .gpr_write_addr_sel(ns_gpr_write_addr_sel), .gpr_write_data_sel(ns_gpr_write_data_sel),
    .ext_ctl(ns_ext_ctl), .npc_sel(ns_npc_sel), .alu_src_ctl(ns_alu_src_ctl), .dm_sel(ns_dm_sel),
    .halt_sig(ns_halt_sig), .bad_inst(ns_bad_inst), .state(ns_state), .cycle_cnt(ns_cycle_cnt),
    .inst_cnt(ns_inst_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dec_inst = C_SUBU; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    ntests++; if (state !== 3'd0) begin nfail++; $display("FAIL reset_state: got %0d want 0", state); end
    ntests++; if ({pc_write_en, ir_write_en, reg_write_en, mem_write_en, mem_read_en, halt_sig, bad_inst} !== 7'b0) begin
      nfail++; $display("FAIL reset_strobes: got %b want 0", {pc_write_en, ir_write_en, reg_write_en, mem_write_en, mem_read_en, halt_sig, bad_inst}); end
    ntests++; if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin
      nfail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, inst_cnt); end
    ntests++; if (alu_sel !== 2'd1 || alu_src_ctl !== 1'b0 || gpr_write_addr_sel !== 2'd1) begin
      nfail++; $display("FAIL reset_selects: got alu=%0d src=%0d addr=%0d want 1/0/1", alu_sel, alu_src_ctl, gpr_write_addr_sel); end
  endtask

  task automatic test_addu();
    logic [2:0] st_seq [4];
    logic       rw_seq [4];
    st_seq = '{3'd0, 3'd1, 3'd2, 3'd4};
    rw_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dec_inst = C_ADDU; mem_ready = 1'b1;
      #1;
      ntests++; if (state !== st_seq[i]) begin nfail++; $display("FAIL addu_state[%0d]: got %0d want %0d", i, state, st_seq[i]); end
      ntests++; if (reg_write_en !== rw_seq[i]) begin nfail++; $display("FAIL addu_reg_we[%0d]: got %b want %b", i, reg_write_en, rw_seq[i]); end
      if (i == 3) begin
        ntests++; if (gpr_write_addr_sel !== 2'd1 || gpr_write_data_sel !== 2'd0) begin
          nfail++; $display("FAIL addu_wb_sels: got %0d/%0d want 1/0", gpr_write_addr_sel, gpr_write_data_sel); end
      end
      tick();
    end
    ntests++; if (state !== 3'd0) begin nfail++; $display("FAIL addu_end_state: got %0d want 0", state); end
    ntests++; if (inst_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
      nfail++; $display("FAIL addu_counters: got inst=%0d cyc=%0d want 1/4", inst_cnt, cycle_cnt); end
  endtask

  task automatic test_lw_stall();
    exp_mr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st  = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    exp_irw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_mrd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rwe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      dec_inst = C_LW; mem_ready = exp_mr[i];
      #1;
      ntests++; if (state !== exp_st[i]) begin nfail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      ntests++; if ({ir_write_en, mem_read_en, reg_write_en, mem_write_en} !== {exp_irw[i], exp_mrd[i], exp_rwe[i], 1'b0}) begin
        nfail++; $display("FAIL lw_strobes[%0d]: got %b want %b", i, {ir_write_en, mem_read_en, reg_write_en, mem_write_en},
                          {exp_irw[i], exp_mrd[i], exp_rwe[i], 1'b0}); end
      if (exp_st[i] == 3'd3) begin
        ntests++; if (inst_fetch !== 1'b0) begin nfail++; $display("FAIL lw_inst_fetch[%0d]: got %b want 0", i, inst_fetch); end
      end
      tick();
    end
    ntests++; if (state !== 3'd0 || cycle_cnt !== 32'd9 || inst_cnt !== 32'd1) begin
      nfail++; $display("FAIL lw_end: got st=%0d cyc=%0d inst=%0d want 0/9/1", state, cycle_cnt, inst_cnt); end
  endtask

  task automatic test_beq();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      dec_inst = C_BEQ; mem_ready = 1'b1; zero = (pass == 0);
      tick();
      tick();
      #1;
      ntests++; if (state !== 3'd2) begin nfail++; $display("FAIL beq_exec_state[%0d]: got %0d want 2", pass, state); end
      ntests++; if (pc_write_en !== (pass == 0) || npc_sel !== 2'd1) begin
        nfail++; $display("FAIL beq_exec[%0d]: got pc_we=%b npc=%0d want %b/1", pass, pc_write_en, npc_sel, (pass == 0)); end
      tick();
      ntests++; if (state !== 3'd0 || inst_cnt !== 32'(pass + 1)) begin
        nfail++; $display("FAIL beq_end[%0d]: got st=%0d inst=%0d want 0/%0d", pass, state, inst_cnt, pass + 1); end
    end
    zero = 1'b0;
    ntests++; if (cycle_cnt !== 32'd6) begin nfail++; $display("FAIL beq_cycles: got %0d want 6", cycle_cnt); end
  endtask

  task automatic test_addi_overflow();
    do_reset();
    dec_inst = C_ADDI; mem_ready = 1'b1; overflow = 1'b1;
    tick();
    tick();
    tick();
    #1;
    ntests++; if (state !== 3'd4) begin nfail++; $display("FAIL addi_state: got %0d want 4", state); end
    ntests++; if (reg_write_en !== 1'b0 || reg_of_en !== 1'b1) begin
      nfail++; $display("FAIL addi_suppress: got we=%b of=%b want 0/1", reg_write_en, reg_of_en); end
    ntests++; if (ns_reg_write_en !== 1'b1 || ns_reg_of_en !== 1'b1) begin
      nfail++; $display("FAIL addi_nosuppress: got we=%b of=%b want 1/1", ns_reg_write_en, ns_reg_of_en); end
    overflow = 1'b0;
    #1;
    ntests++; if (reg_write_en !== 1'b1) begin nfail++; $display("FAIL addi_no_overflow: got we=%b want 1", reg_write_en); end
    tick();
  endtask

  task automatic test_bad_inst();
    do_reset();
    dec_inst = C_BAD; mem_ready = 1'b1;
    #1;
    ntests++; if (bad_inst !== 1'b0) begin nfail++; $display("FAIL bad_in_fetch: got %b want 0", bad_inst); end
    tick();
    ntests++; if (state !== 3'd1 || bad_inst !== 1'b1) begin
      nfail++; $display("FAIL bad_pulse: got st=%0d bad=%b want 1/1", state, bad_inst); end
    ntests++; if ({pc_write_en, ir_write_en, reg_write_en, mem_write_en, mem_read_en} !== 5'b0) begin
      nfail++; $display("FAIL bad_strobes: got %b want 0", {pc_write_en, ir_write_en, reg_write_en, mem_write_en, mem_read_en}); end
    tick();
    ntests++; if (state !== 3'd0 || bad_inst !== 1'b0 || inst_cnt !== 32'd0 || cycle_cnt !== 32'd2) begin
      nfail++; $display("FAIL bad_end: got st=%0d bad=%b inst=%0d cyc=%0d want 0/0/0/2", state, bad_inst, inst_cnt, cycle_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dec_inst = C_JAL; mem_ready = 1'b1;
    tick();
    ntests++; if ({pc_write_en, reg_write_en} !== 2'b11 || npc_sel !== 2'd2) begin
      nfail++; $display("FAIL jal_decode: got pc/rw=%b npc=%0d want 11/2", {pc_write_en, reg_write_en}, npc_sel); end
    ntests++; if (gpr_write_addr_sel !== 2'd2 || gpr_write_data_sel !== 2'd2) begin
      nfail++; $display("FAIL jal_sels: got %0d/%0d want 2/2", gpr_write_addr_sel, gpr_write_data_sel); end
    tick();
    dec_inst = C_SW;
    #1;
    ntests++; if (state !== 3'd0 || inst_cnt !== 32'd1) begin
      nfail++; $display("FAIL jal_end: got st=%0d inst=%0d want 0/1", state, inst_cnt); end
    tick();
    tick();
    tick();
    ntests++; if (state !== 3'd3 || mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin
      nfail++; $display("FAIL sw_mem: got st=%0d w=%b r=%b want 3/1/0", state, mem_write_en, mem_read_en); end
    tick();
    ntests++; if (state !== 3'd0 || inst_cnt !== 32'd2 || cycle_cnt !== 32'd6) begin
      nfail++; $display("FAIL sw_end: got st=%0d inst=%0d cyc=%0d want 0/2/6", state, inst_cnt, cycle_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    dec_inst = C_HLT; mem_ready = 1'b1;
    tick();
    ntests++; if (state !== 3'd1 || halt_sig !== 1'b0) begin
      nfail++; $display("FAIL hlt_decode: got st=%0d halt=%b want 1/0", state, halt_sig); end
    tick();
    ntests++; if (state !== 3'd5 || halt_sig !== 1'b1 || inst_cnt !== 32'd1 || cycle_cnt !== 32'd2) begin
      nfail++; $display("FAIL hlt_enter: got st=%0d halt=%b inst=%0d cyc=%0d want 5/1/1/2", state, halt_sig, inst_cnt, cycle_cnt); end
    for (int i = 0; i < 10; i++) begin
      dec_inst = C_ADDU; mem_ready = i[0];
      tick();
      ntests++; if (halt_sig !== 1'b1 || cycle_cnt !== 32'd2 || pc_write_en !== 1'b0) begin
        nfail++; $display("FAIL hlt_hold[%0d]: got halt=%b cyc=%0d pc_we=%b want 1/2/0", i, halt_sig, cycle_cnt, pc_write_en); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    ntests++; if (state !== 3'd0 || halt_sig !== 1'b0 || cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin
      nfail++; $display("FAIL hlt_reset: got st=%0d halt=%b cyc=%0d inst=%0d want 0/0/0/0", state, halt_sig, cycle_cnt, inst_cnt); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_addi_overflow();
    test_bad_inst();
    test_back_to_back();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle MIPS decode controller. A registered FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on a memory ready handshake, and issues one-cycle write strobes. Datapath selects stay decode-driven. It adds sticky halt, bad-instruction reporting, optional overflow write suppression, and cycle/retired-instruction counters. It sits between the IR/decoder and the PC, GPR, ALU, EXT and DM.

## Interface
- INST_W, 6: width of decoded instruction code `dec_inst`; codes are the `INST_*` defines.
- CNT_W, 32: width of the cycle and retired-instruction counters.
- OF_SUPPRESS, 1: 1 = gate GPR write when `reg_of_en & overflow`; 0 = always write, leave handling to the GPR.
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- dec_inst  in  INST_W  decoded code of the instruction held in the IR.
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed overflow flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write_en, ir_write_en  out  1  PC and IR load strobes.
- reg_write_en, reg_of_en, mem_write_en, mem_read_en  out  1  GPR and DM strobes.
- inst_fetch  out  1  memory address is the PC (1) or the ALU result (0).
- alu_sel, gpr_write_addr_sel, gpr_write_data_sel, ext_ctl, npc_sel  out  2  datapath selects, same encodings as the defines.
- alu_src_ctl, dm_sel  out  1  ALU B source; byte/word access.
- halt_sig  out  1  processor halted.
- bad_inst  out  1  one-cycle pulse on an undefined instruction.
- state  out  3  current FSM state.
- cycle_cnt, inst_cnt  out  CNT_W  cycles since reset; retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to FETCH.
- Selects: `alu_sel`, `alu_src_ctl`, `ext_ctl`, `gpr_write_*_sel` and `dm_sel` decode combinationally from `dec_inst` in every state.
  - Per-instruction values match the single-cycle decode table.
  - Default: ADD, EXT, SIGN, RT, ALU, WORD.
- Strobes default to 0. They are asserted only as listed below.
- FETCH: `inst_fetch=1`, `mem_read_en=1`.
  - When `mem_ready`: `ir_write_en=1`, `pc_write_en=1`, `npc_sel=NORM`, then DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - HLT: go to HALT.
  - J: `pc_write_en=1`, IRRELATIVE, then FETCH.
  - JAL: as J, plus `reg_write_en=1` with sel RA/PC (PC already holds PC+4).
  - JR: `pc_write_en=1`, REGISTER, then FETCH.
  - Undefined code: `bad_inst=1`, no writes, then FETCH; `inst_cnt` does not increment.
  - All others: go to EXEC.
- EXEC:
  - BEQ: `pc_write_en=zero`, `npc_sel=RELATIVE`, then FETCH.
  - LW/LB/SW/SB: go to MEM.
  - ADDU/SUBU/ORI/LUI/ADDI/ADDIU/SLT: go to WB.
- MEM: `inst_fetch=0`.
  - Loads assert `mem_read_en`; stores assert `mem_write_en`.
  - Hold until `mem_ready`; then loads go to WB and stores go to FETCH.
  - `mem_write_en` stays high during a stall. The DM commits only on the `mem_ready` cycle.
- WB: `reg_write_en = ~(OF_SUPPRESS & reg_of_en & overflow)`; then FETCH. `reg_of_en=1` only for ADDI.
- HALT: `halt_sig=1`, all strobes 0. Stays in HALT until `rst`; inputs are ignored.
- `inst_cnt` increments on each transition back to FETCH from DECODE, EXEC, MEM or WB, except for a bad instruction. Entering HALT also counts as retiring HLT.
- `cycle_cnt` increments every cycle except in HALT. Both counters wrap modulo 2^CNT_W.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Reset values: state=FETCH; all strobes, `halt_sig`, `bad_inst` = 0; counters = 0. Selects show the decode of `dec_inst`.
- `rst` has priority over every transition. Reset mid-stall or in HALT returns to FETCH on the next edge.
- Strobes, `halt_sig` and `bad_inst` are Moore/Mealy functions of the registered state plus `dec_inst`/`zero`/`overflow`/`mem_ready`. There are no extra pipeline registers.
- Latency with zero-wait memory (`mem_ready` high): J/JAL/JR 2 cycles, BEQ 3, ALU and store 4, load 5, HLT 2 to `halt_sig`.
- Each cycle with `mem_ready` low in FETCH or MEM adds one cycle.

## Structure
- State encodings `ST_*` and the width of `state` go in the shared `defines.v`, next to the existing `INST_*`, `ALU_SEL_*` and `IFU_SEL_*` constants.
- One sub-module: `mc_perf_counter`, a CNT_W-wide counter with synchronous clear and enable. It is instantiated twice, once for `cycle_cnt` and once for `inst_cnt`.
- The FSM register, next-state logic and decode table live in `multicycle_controller`.

## Test plan
- ADDU with zero-wait memory: states 0,1,2,4,0; `reg_write_en` high only in WB, with RD/ALU sels; `inst_cnt` goes 0→1 and `cycle_cnt`=4.
- LW with `mem_ready` low for 2 cycles in both FETCH and MEM: 9 cycles total; `ir_write_en` and `mem_read_en` pulses align with the `mem_ready` cycles.
- BEQ: with zero=1, `pc_write_en`=1 and `npc_sel`=RELATIVE in EXEC; with zero=0, `pc_write_en`=0; back to FETCH after 3 cycles either way.
- ADDI with overflow=1, OF_SUPPRESS=1: `reg_write_en`=0 in WB. With OF_SUPPRESS=0: `reg_write_en`=1 and `reg_of_en`=1.
- Undefined `dec_inst`=6'h3F: one-cycle `bad_inst`, no strobes, `inst_cnt` unchanged.
- HLT then 10 cycles: `halt_sig` stays 1 and `cycle_cnt` stays frozen; `rst` pulse gives state=0, `halt_sig`=0, counters=0.
